// File: rtl/priority_encoder_pend_if.sv
// Request/index bundle for the pending priority encoder.
// The producer/consumer side (master) drives capture enable, request lines
// and ack; the encoder (slave) returns the index and status flags.
interface priority_encoder_pend_if #(
  parameter int N     = 4,
  parameter int OUT_W = 2
);
  logic             en;
  logic [N-1:0]     din;
  logic             ack;
  logic [OUT_W-1:0] dout;
  logic             valid;
  logic             multi;
  logic             merged;
  logic [N-1:0]     pend;

  modport master (
    output en, din, ack,
    input  dout, valid, multi, merged, pend
  );

  modport slave (
    input  en, din, ack,
    output dout, valid, multi, merged, pend
  );
endinterface

// File: rtl/priority_encoder_pend.sv
// Sequential N-to-log2(N) priority encoder with pending-request latching.
// Request pulses are accumulated in a pending register; the highest pending
// index is presented until acked. All outputs decode from the register only,
// so there is no combinational path from din or ack to any output.
// N must be a power of two in 2..16 and OUT_W must equal clog2(N).
module priority_encoder_pend #(
  parameter int N     = 4,
  parameter int OUT_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  priority_encoder_pend_if.slave bus
);

  logic [N-1:0]     pend_q;
  logic [N-1:0]     pend_d;
  logic [N-1:0]     cap;
  logic [N-1:0]     clr;
  logic             merged_q;
  logic             merged_d;
  logic [OUT_W-1:0] idx;
  logic [OUT_W:0]   cnt;
  logic             any_pend;

  // Highest set bit wins (later iterations overwrite); also count set bits.
  always_comb begin
    idx = '0;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) begin
        idx = OUT_W'(i);
        cnt = cnt + (OUT_W + 1)'(1);
      end
    end
  end

  assign any_pend = |pend_q;

  // Ack only retires the index currently shown; ack while idle does nothing.
  always_comb begin
    clr = '0;
    if (any_pend && bus.ack) begin
      clr[idx] = 1'b1;
    end
  end

  assign cap = bus.en ? bus.din : '0;

  // Set beats clear on the same bit; a merge is only a hit on a bit that
  // stays pending, so re-requesting a bit being acked is not a merge.
  always_comb begin
    pend_d   = (pend_q & ~clr) | cap;
    merged_d = |(cap & pend_q & ~clr);
  end

  // Pending register and merge pulse, both cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      merged_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      merged_q <= merged_d;
    end
  end

  assign bus.dout   = idx;
  assign bus.valid  = any_pend;
  assign bus.multi  = (cnt > (OUT_W + 1)'(1));
  assign bus.merged = merged_q;
  assign bus.pend   = pend_q;

endmodule
